// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL field layout and write-strobe decode for the multi-channel timer.
package multi_timer_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_EXPR = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  localparam int unsigned CTRL_START      = 0;
  localparam int unsigned CTRL_MODE       = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_PRESC_BASE = 8;

  typedef struct packed {
    logic ctrl;
    logic stat;
    logic expr;
    logic cnt;
  } wr_sel_t;

  function automatic wr_sel_t decode_wr(logic [1:0] reg_sel);
    wr_sel_t sel;
    sel = '0;
    unique case (reg_sel)
      REG_CTRL: sel.ctrl = 1'b1;
      REG_STAT: sel.stat = 1'b1;
      REG_EXPR: sel.expr = 1'b1;
      REG_CNT:  sel.cnt  = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter with compare, sticky expiry flag and control fields.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  wr_sel_t            wr_sel,
  input  logic [31:0]        wr_data,
  output logic [31:0]        ctrl_word,
  output logic               flag,
  output logic               irq_en,
  output logic [CNT_W-1:0]   expr,
  output logic [CNT_W-1:0]   cnt
);

  logic               start_q, start_d;
  logic               mode_q, mode_d;
  logic               irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   expr_q, expr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic               expire;
  logic               unused_wr;

  // Not every write-data bit lands in a field for all parameter choices.
  assign unused_wr = ^wr_data;

  assign tick   = start_q && (pcnt_q == presc_q);
  // A CNT write in the same cycle wins over the compare, so no expiry is taken.
  assign expire = tick && (cnt_q == expr_q) && !wr_sel.cnt;

  always_comb begin
    start_d  = start_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    if (expire && !mode_q) begin
      start_d = 1'b0;
    end
    if (wr_sel.ctrl) begin
      start_d  = wr_data[CTRL_START];
      mode_d   = wr_data[CTRL_MODE];
      irq_en_d = wr_data[CTRL_IRQ_EN];
      presc_d  = wr_data[CTRL_PRESC_BASE +: PRESC_W];
    end
  end

  always_comb begin
    if (!start_q || wr_sel.ctrl || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_comb begin
    if (wr_sel.cnt) begin
      cnt_d = wr_data[CNT_W-1:0];
    end else if (expire) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    flag_d = flag_q;
    if (wr_sel.stat && wr_data[0]) begin
      flag_d = 1'b0;
    end
    // Expiry wins over a coincident write-1-clear.
    if (expire) begin
      flag_d = 1'b1;
    end
  end

  always_comb begin
    expr_d = expr_q;
    if (wr_sel.expr) begin
      expr_d = wr_data[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      flag_q   <= 1'b0;
      expr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      start_q  <= start_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      flag_q   <= flag_d;
      expr_q   <= expr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_START]  = start_q;
    ctrl_word[CTRL_MODE]   = mode_q;
    ctrl_word[CTRL_IRQ_EN] = irq_en_q;
    ctrl_word[CTRL_PRESC_BASE +: PRESC_W] = presc_q;
  end

  assign flag   = flag_q;
  assign irq_en = irq_en_q;
  assign expr   = expr_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: bus decode, registered read path and acknowledge, interrupt combine.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned CNT_W   = 32,
  parameter  int unsigned PRESC_W = 8,
  localparam int unsigned AW      = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              as,
  input  logic              rw,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  logic              access;
  logic              wr_access;
  logic [AW-1:0]     ch_sel;
  logic [1:0]        reg_sel;
  logic [31:0]       rd_sel;
  logic [31:0]       ctrl_word [NUM_CH];
  logic [CNT_W-1:0]  expr      [NUM_CH];
  logic [CNT_W-1:0]  cnt       [NUM_CH];
  logic [NUM_CH-1:0] flag;
  logic [NUM_CH-1:0] irq_en;

  assign access    = cs && as;
  assign wr_access = access && rw;
  // Shift rather than slice so a single-channel build (AW == 2) still elaborates.
  assign ch_sel    = addr >> 2;
  assign reg_sel   = addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wr_sel_t wr_sel;

    assign wr_sel = (wr_access && (ch_sel == AW'(i))) ? decode_wr(reg_sel) : '0;

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .ctrl_word (ctrl_word[i]),
      .flag      (flag[i]),
      .irq_en    (irq_en[i]),
      .expr      (expr[i]),
      .cnt       (cnt[i])
    );
  end

  // Unpopulated channel indices match no entry and read back as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_CTRL: rd_sel = ctrl_word[i];
          REG_STAT: rd_sel = {31'b0, flag[i]};
          REG_EXPR: rd_sel = 32'(expr[i]);
          default:  rd_sel = 32'(cnt[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rdy     <= 1'b0;
    end else begin
      rdy     <= access;
      rd_data <= (access && !rw) ? rd_sel : '0;
    end
  end

  assign irq_vec = flag & irq_en;
  assign irq     = |irq_vec;

endmodule
